// File: rtl/print_uart_tx_if.sv
// rtl/print_uart_tx_if.sv - print-port and UART status bundle for print_uart_tx
interface print_uart_tx_if;
  logic [31:0] PRINT_VAL;
  logic        PRINT_EN;
  logic        TX;
  logic        BUSY;
  logic        FIFO_FULL;
  logic        OVERFLOW;

  // Core side: writes words, observes the line and status
  modport master (
    output PRINT_VAL, PRINT_EN,
    input  TX, BUSY, FIFO_FULL, OVERFLOW
  );

  // Transmitter side
  modport slave (
    input  PRINT_VAL, PRINT_EN,
    output TX, BUSY, FIFO_FULL, OVERFLOW
  );
endinterface

// File: rtl/print_uart_tx.sv
// rtl/print_uart_tx.sv - word FIFO + 8N1 UART transmitter; PRINT_ASCII_HEX_EN selects hex text output
module print_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic           CLK,
  input  logic           RESET_N,
  print_uart_tx_if.slave prt
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef PRINT_ASCII_HEX_EN
  localparam int NCHARS = 10;
`else
  localparam int NCHARS = 4;
`endif
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       CHAR_LAST = 4'(NCHARS - 1);
  localparam logic [PTR_W:0]   FIFO_MAX  = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  // Character idx of a word: hex digits MS nibble first then CR LF, or raw bytes LS first
  function automatic logic [7:0] char_of(input logic [31:0] w, input logic [3:0] idx);
    logic [31:0] sh;
    logic [3:0]  nib;
`ifdef PRINT_ASCII_HEX_EN
    sh  = w << {idx, 2'b00};
    nib = sh[31:28];
    if (idx == 4'd8)       char_of = 8'h0D;
    else if (idx == 4'd9)  char_of = 8'h0A;
    else if (nib < 4'd10)  char_of = 8'h30 + {4'h0, nib};
    else                   char_of = 8'h37 + {4'h0, nib};
`else
    sh      = w >> {idx, 3'b000};
    nib     = 4'h0;
    char_of = sh[7:0] | {4'h0, nib};
`endif
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [3:0]       char_idx_q, char_idx_d;
  logic [31:0]      word_q, word_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             overflow_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      mem_q [FIFO_DEPTH];

  logic        fifo_full, fifo_empty, bit_end, pop, push, ovf_set;
  logic [31:0] head;
  logic [3:0]  nxt_char;

  assign fifo_full  = (count_q == FIFO_MAX);
  assign fifo_empty = (count_q == '0);
  assign bit_end    = (bit_cnt_q == BIT_LAST);
  assign head       = mem_q[rd_ptr_q];
  assign nxt_char   = char_idx_q + 4'd1;

  // Next-state: frame sequencing, FIFO pop/push arbitration and overflow detection
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    char_idx_d = char_idx_q;
    word_d     = word_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;

    if (state_q != IDLE) begin
      bit_cnt_d = bit_end ? '0 : bit_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          word_d     = head;
          char_idx_d = '0;
          shift_d    = char_of(head, 4'd0);
          tx_d       = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (char_idx_q != CHAR_LAST) begin
            char_idx_d = nxt_char;
            shift_d    = char_of(word_q, nxt_char);
            tx_d       = 1'b0;
            state_d    = START;
          end else if (!fifo_empty) begin
            pop        = 1'b1;
            word_d     = head;
            char_idx_d = '0;
            shift_d    = char_of(head, 4'd0);
            tx_d       = 1'b0;
            state_d    = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    // A full FIFO still accepts a write when the same edge frees a slot
    push     = prt.PRINT_EN && (!fifo_full || pop);
    ovf_set  = prt.PRINT_EN && fifo_full && !pop;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State register; reset abandons any frame in flight and empties the FIFO
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      char_idx_q <= '0;
      word_q     <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      char_idx_q <= char_idx_d;
      word_q     <= word_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_q | ovf_set;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; writes are ignored while reset is held
  always_ff @(posedge CLK) begin
    if (RESET_N && push) begin
      mem_q[wr_ptr_q] <= prt.PRINT_VAL;
    end
  end

  assign prt.TX        = tx_q;
  assign prt.BUSY      = (state_q != IDLE) || !fifo_empty;
  assign prt.FIFO_FULL = fifo_full;
  assign prt.OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_print_uart_tx.sv
// tb/tb_print_uart_tx.sv - self-checking bench for print_uart_tx with a UART receiver and byte-stream model
module tb_print_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef PRINT_ASCII_HEX_EN
  localparam int NCH = 10;
`else
  localparam int NCH = 4;
`endif
  localparam int WORD_CYC = NCH * 10 * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  byte unsigned exp_q[$];
  byte unsigned rx_q[$];

  print_uart_tx_if bus();

  print_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .prt     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected byte stream of one word, straight from the output format rules
  function automatic void model_word(input logic [31:0] w);
`ifdef PRINT_ASCII_HEX_EN
    string hexd;
    hexd = "0123456789ABCDEF";
    for (int i = 0; i < 8; i++) exp_q.push_back(hexd[int'((w >> (28 - 4*i)) & 32'hF)]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(8'((w >> (8*i)) & 32'hFF));
`endif
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    int g;
    g = 0;
    while (cyc < target && g < 50000) begin
      step();
      g++;
    end
    chk("wait_target", cyc, target);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (bus.BUSY !== 1'b0 && n < limit) begin
      step();
      n++;
    end
    chk("idle_timeout", bus.BUSY, 0);
    repeat (2) step();
  endtask

  task automatic write_word(input logic [31:0] w, input bit expect_tx);
    bus.PRINT_VAL = w;
    bus.PRINT_EN  = 1'b1;
    if (expect_tx) model_word(w);
    step();
    bus.PRINT_EN  = 1'b0;
  endtask

  task automatic compare_rx(input string tag);
    chk({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  // Line receiver: every sample within a bit must agree, start=0, stop=1
  initial begin
    logic [9:0] smp;
    bit steady, aborted;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.TX === 1'b0) begin
        smp = '0;
        steady = 1'b1;
        aborted = 1'b0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int s = 0; s < CPB && !aborted; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (rst_n !== 1'b1) aborted = 1'b1;
            else if (s == 0) smp[b] = bus.TX;
            else if (bus.TX !== smp[b]) steady = 1'b0;
          end
        end
        if (!aborted) begin
          chk("frame", {29'd0, steady, smp[9], smp[0]}, {29'd0, 1'b1, 1'b1, 1'b0});
          rx_q.push_back(smp[8:1]);
        end
      end
    end
  end

  initial begin
    logic [31:0] w;
    int e1, p, lowcnt;
    bit saw_low;

    // Reset with PRINT_EN held high: nothing may be queued
    bus.PRINT_VAL = $urandom;
    bus.PRINT_EN  = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    bus.PRINT_EN = 1'b0;
    chk("rst_tx", bus.TX, 1);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_full", bus.FIFO_FULL, 0);
    chk("rst_ovf", bus.OVERFLOW, 0);
    repeat (3) step();
    chk("rst_en_ignored", bus.BUSY, 0);

    // Idle latency, start-bit width, word duration, BUSY drop
    w = {4'h1, 27'($urandom), 1'b1};
    write_word(w, 1'b1);
    e1 = cyc;
    p  = e1 + 1;
    chk("lat_tx_high_at_accept", bus.TX, 1);
    chk("lat_busy", bus.BUSY, 1);
    step();
    chk("lat_tx_low_next_edge", bus.TX, 0);
    lowcnt = 0;
    while (bus.TX === 1'b0 && lowcnt < 4*CPB) begin
      lowcnt++;
      step();
    end
    chk("start_width", lowcnt, CPB);
    wait_until(p + WORD_CYC - 1);
    chk("busy_last_cycle", bus.BUSY, 1);
    step();
    chk("busy_drop", bus.BUSY, 0);
    chk("tx_idle", bus.TX, 1);
    repeat (2) step();
    compare_rx("single");

    // Directed words back-to-back, then random words with random gaps
    write_word(32'h12345678, 1'b1);
    write_word(32'h000000FF, 1'b1);
    write_word(32'hDEADBEEF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      write_word($urandom, 1'b1);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle(10 * WORD_CYC);
    compare_rx("stream");

    // Ten back-to-back writes: one popped, eight queued, tenth dropped
    for (int i = 0; i < 10; i++) begin
      write_word($urandom, i < 9);
      if (i == 7) chk("full_before_w9", bus.FIFO_FULL, 0);
      if (i == 8) begin
        chk("full_after_w9", bus.FIFO_FULL, 1);
        chk("ovf_before_w10", bus.OVERFLOW, 0);
      end
    end
    chk("ovf_after_w10", bus.OVERFLOW, 1);
    chk("full_after_w10", bus.FIFO_FULL, 1);
    wait_idle(10 * WORD_CYC);
    compare_rx("overflow");
    chk("ovf_sticky", bus.OVERFLOW, 1);

    // Write on the exact edge the full FIFO is popped at end of word
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("ovf_cleared", bus.OVERFLOW, 0);
    for (int i = 0; i < 9; i++) begin
      write_word($urandom, 1'b1);
      if (i == 0) e1 = cyc;
    end
    chk("pop_full_pre", bus.FIFO_FULL, 1);
    p = e1 + 1;
    wait_until(p + WORD_CYC - 1);
    chk("pop_full_at_edge", bus.FIFO_FULL, 1);
    write_word($urandom, 1'b1);
    chk("pop_push_ovf", bus.OVERFLOW, 0);
    chk("pop_push_full", bus.FIFO_FULL, 1);
    wait_idle(11 * WORD_CYC);
    compare_rx("pop_push");
    chk("pop_push_ovf_end", bus.OVERFLOW, 0);

    // Reset during data bit 3 abandons the frame and the queue
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      w[31] = 1'b0;
      w[3]  = 1'b0;
      write_word(w, 1'b0);
      if (i == 0) e1 = cyc;
    end
    p = e1 + 1;
    wait_until(p + 4*CPB);
    chk("bit3_low", bus.TX, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_tx", bus.TX, 1);
    chk("abort_busy", bus.BUSY, 0);
    chk("abort_ovf", bus.OVERFLOW, 0);
    chk("abort_full", bus.FIFO_FULL, 0);
    saw_low = 1'b0;
    repeat (3 * WORD_CYC) begin
      step();
      if (bus.TX !== 1'b1) saw_low = 1'b1;
    end
    chk("abort_no_resume", saw_low, 0);
    chk("abort_busy_end", bus.BUSY, 0);
    chk("abort_rx_empty", rx_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
